// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EXE/MEM status in, stall and forward controls out.
// The slave modport is the controller's view; the master modport is the pipeline side.
interface pipe_hazard_ctrl_if #(
    parameter int RN_W = 5
);
    logic [RN_W-1:0] rs;
    logic [RN_W-1:0] rt;
    logic            use_rs;
    logic            use_rt;
    logic            ewreg;
    logic            em2reg;
    logic [RN_W-1:0] ern;
    logic            mwreg;
    logic            mm2reg;
    logic [RN_W-1:0] mrn;
    logic            mem_req;
    logic            dmem_ready;
    logic            wpcir;
    logic            id_bubble;
    logic            pipe_hold;
    logic [1:0]      fwda;
    logic [1:0]      fwdb;
    logic            err;

    modport master (
        output rs, rt, use_rs, use_rt, ewreg, em2reg, ern,
               mwreg, mm2reg, mrn, mem_req, dmem_ready,
        input  wpcir, id_bubble, pipe_hold, fwda, fwdb, err
    );

    modport slave (
        input  rs, rt, use_rs, use_rt, ewreg, em2reg, ern,
               mwreg, mm2reg, mrn, mem_req, dmem_ready,
        output wpcir, id_bubble, pipe_hold, fwda, fwdb, err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline (sits in ID).
// Forwarding selects, load-use bubble insertion, memory-wait freeze with timeout.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall_cnt / bubble_cnt ports.
module pipe_hazard_ctrl #(
    parameter int RN_W     = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    logic [1:0] state, state_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       memwait;
    logic       lu;
    logic       wpcir_i, bubble_i, hold_i;

    // EXE result beats MEM result; a load still in EXE has no data to forward.
    function automatic logic [1:0] fwd_sel(
        input logic [RN_W-1:0] x,
        input logic            ewreg,
        input logic            em2reg,
        input logic [RN_W-1:0] ern,
        input logic            mwreg,
        input logic            mm2reg,
        input logic [RN_W-1:0] mrn
    );
        if (ewreg && ern != '0 && ern == x && !em2reg)
            return 2'b01;
        else if (mwreg && mrn != '0 && mrn == x)
            return mm2reg ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    assign memwait = hz.mem_req & ~hz.dmem_ready;
    assign lu      = hz.ewreg & hz.em2reg & (hz.ern != '0) &
                     ((hz.use_rs & (hz.ern == hz.rs)) | (hz.use_rt & (hz.ern == hz.rt)));

    // Stall decode and next-state: memory wait outranks load-use, ERR freezes everything.
    always_comb begin
        wpcir_i     = 1'b1;
        bubble_i    = 1'b0;
        hold_i      = 1'b0;
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        case (state)
            ST_RUN, ST_WAIT: begin
                if (memwait) begin
                    wpcir_i = 1'b0;
                    hold_i  = 1'b1;
                    if (state == ST_RUN) begin
                        state_nx    = ST_WAIT;
                        wait_cnt_nx = 8'd1;
                    end else if (wait_cnt == WAIT_LIM) begin
                        state_nx = ST_ERR;
                    end else begin
                        wait_cnt_nx = wait_cnt + 8'd1;
                    end
                end else begin
                    // Hold released: the frozen ID instruction is re-checked for load-use now.
                    state_nx    = ST_RUN;
                    wait_cnt_nx = 8'd0;
                    if (lu) begin
                        wpcir_i  = 1'b0;
                        bubble_i = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                wpcir_i  = 1'b0;
                bubble_i = 1'b1;
                hold_i   = 1'b1;
            end
            default: begin
                state_nx    = ST_RUN;
                wait_cnt_nx = 8'd0;
            end
        endcase
    end

    // Output drive; reset forces a safe nop-insert with no forwarding.
    always_comb begin
        if (rst) begin
            hz.wpcir     = 1'b0;
            hz.id_bubble = 1'b1;
            hz.pipe_hold = 1'b0;
            hz.fwda      = 2'b00;
            hz.fwdb      = 2'b00;
            hz.err       = 1'b0;
        end else begin
            hz.wpcir     = wpcir_i;
            hz.id_bubble = bubble_i;
            hz.pipe_hold = hold_i;
            hz.fwda      = fwd_sel(hz.rs, hz.ewreg, hz.em2reg, hz.ern, hz.mwreg, hz.mm2reg, hz.mrn);
            hz.fwdb      = fwd_sel(hz.rt, hz.ewreg, hz.em2reg, hz.ern, hz.mwreg, hz.mm2reg, hz.mrn);
            hz.err       = (state == ST_ERR);
        end
    end

    // State and wait counter; ERR is left only through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating counts of stalled-fetch cycles and inserted bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (!wpcir_i && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (bubble_i && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
